// File: rtl/cpu_fetch_unit.sv
// cpu_fetch_unit: decoupled instruction-fetch front end.
// Issues word-aligned fetch requests under a credit limit so the prefetch
// queue can never overflow. Responses are pushed into the queue in order,
// and {pc, instr} pairs are delivered to decode over a valid/ready handshake.
// A redirect flushes the queue, restarts fetch at a new PC, and arranges
// for every response still in flight to be discarded when it returns.
module cpu_fetch_unit #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,

    // instruction-memory request channel
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,

    // instruction-memory response channel (in order, no backpressure)
    input  logic                  imem_rsp_valid,
    input  logic [31:0]           imem_rsp_data,

    // decode-side channel
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [31:0]           instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc,

    // control
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  halt
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Counters must hold the value DEPTH itself, hence one extra bit.
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [CNT_W:0]        CREDIT_LIMIT = (CNT_W + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP      = ADDR_WIDTH'(4);
    localparam logic [PTR_W-1:0]      PTR_ONE      = PTR_W'(1);
    localparam logic [CNT_W-1:0]      CNT_ONE      = CNT_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] head_pc_q, head_pc_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic [CNT_W-1:0]      drop_q, drop_d;
    logic [31:0]           mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] redirect_pc_aligned;
    logic [CNT_W:0]        credit_used;
    logic                  credit_ok;
    logic                  req_fire;
    logic                  pop;
    logic                  push;
    logic                  rsp_discard;

    // The low two bits of a redirect target are meaningless for word fetch.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign redirect_pc_aligned = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

    // Every accepted request reserves a queue slot until its word is
    // popped, so queued plus in-flight words can never exceed DEPTH.
    assign credit_used = {1'b0, count_q} + {1'b0, outstanding_q};
    assign credit_ok   = credit_used < CREDIT_LIMIT;

    // Gated by rst so nothing is offered to memory while reset is held.
    assign imem_req_valid = !rst && !halt && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign instr_valid = (count_q != '0);
    assign instr_data  = mem_q[rd_ptr_q];
    assign instr_pc    = head_pc_q;
    assign pop         = instr_valid && instr_ready;

    // A response is discarded if it predates a redirect (drop pending) or
    // arrives in the same cycle as a redirect.
    assign rsp_discard = imem_rsp_valid && (drop_q != '0);
    assign push        = imem_rsp_valid && (drop_q == '0) && !redirect_valid;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------

    // Program-counter tracking for the fetch side and the queue head.
    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that
        // leaves one unassigned would infer a latch.
        fetch_pc_d = fetch_pc_q;
        head_pc_d  = head_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc_aligned;
            head_pc_d  = redirect_pc_aligned;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (pop) begin
                head_pc_d = head_pc_q + PC_STEP;
            end
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue even if
    // a consume completed in the same cycle.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // In-flight bookkeeping: outstanding requests and responses to drop.
    always_comb begin
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
        drop_d        = drop_q;
        if (redirect_valid) begin
            // Everything still in flight after this cycle's response is
            // stale. drop never exceeds outstanding, so this also covers
            // any drops left over from an earlier redirect.
            drop_d = outstanding_d;
        end else if (rsp_discard) begin
            drop_d = drop_q - CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Control and pointer state, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge inputs regardless of block order.
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            head_pc_q     <= RESET_PC;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            head_pc_q     <= head_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    // Instruction storage: write the accepted response at the tail.
    always_ff @(posedge clk) begin
        // NOTE: the data array is deliberately not reset; occupancy gates
        // instr_valid, so stale contents are never observed and the array
        // can map onto plain flops or a register file.
        if (push) begin
            mem_q[wr_ptr_q] <= imem_rsp_data;
        end
    end

endmodule
